// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debounce bank: per-channel state
// encoding and the counter width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } btn_state_t;

    // Bits needed to hold every value from 0 up to max_value.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// Shared sample-tick prescaler: a one-clk registered strobe every TICK_DIV clocks.
module debounce_tick_gen
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DW = cnt_width(TICK_DIV - 1);
    localparam logic [DW-1:0] CNT_LAST = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0] CNT_PRE  = DW'(TICK_DIV - 2);

    logic [DW-1:0] div_cnt;

    // tick is registered one count early so it is high while div_cnt == TICK_DIV-1
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == CNT_LAST) ? '0 : div_cnt + 1'b1;
            tick    <= (div_cnt == CNT_PRE);
        end
    end

endmodule

// File: rtl/pb_debounce_bank.sv
// Bank of push-button conditioners sharing one sample tick: per channel a
// two-flop synchroniser, a tick-based stability filter and a press/hold FSM.
module pb_debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] pb,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] long_press,
    output logic                tick
);

    localparam int SW = cnt_width(STABLE_TICKS);
    localparam int HW = cnt_width(LONG_TICKS);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

    debounce_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          s1, s2, lvl;
        logic [SW-1:0] stab_cnt;
        logic [HW-1:0] hold_cnt;
        btn_state_t    state, state_nxt;
        logic          stab_done, rise_acc, fall_acc, hold_done;
        logic          press_nxt, release_nxt, long_nxt, hold_clr, hold_inc;
        logic          press_q, release_q, long_q;

        // The filter accepts a change on the tick that completes the run of differing samples.
        assign stab_done = tick && (s2 != lvl) && (stab_cnt == STAB_LAST);
        assign rise_acc  = stab_done && s2;
        assign fall_acc  = stab_done && !s2;
        assign hold_done = tick && (hold_cnt == HOLD_LAST);

        always_ff @(posedge clk) begin
            if (reset) begin
                s1       <= 1'b0;
                s2       <= 1'b0;
                lvl      <= 1'b0;
                stab_cnt <= '0;
            end else begin
                s1 <= pb[i];
                s2 <= s1;
                if (tick) begin
                    if (s2 == lvl) begin
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        lvl      <= s2;
                        stab_cnt <= '0;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state     <= RELEASED;
                hold_cnt  <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state     <= state_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                long_q    <= long_nxt;
                if (hold_clr) begin
                    hold_cnt <= '0;
                end else if (hold_inc) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end

        // A fall accepted on the long-press tick takes priority over the long press.
        always_comb begin
            state_nxt = state;
            case (state)
                RELEASED: if (rise_acc) state_nxt = PRESSED;
                PRESSED: begin
                    if (fall_acc) begin
                        state_nxt = RELEASED;
                    end else if (hold_done) begin
                        state_nxt = HELD;
                    end
                end
                HELD:     if (fall_acc) state_nxt = RELEASED;
                default:  state_nxt = RELEASED;
            endcase
        end

        always_comb begin
            press_nxt   = (state == RELEASED) && rise_acc;
            release_nxt = ((state == PRESSED) || (state == HELD)) && fall_acc;
            long_nxt    = (state == PRESSED) && !fall_acc && hold_done;
            hold_clr    = press_nxt;
            hold_inc    = (state == PRESSED) && tick && !fall_acc;
        end

        assign level[i]      = lvl;
        assign pressed[i]    = press_q;
        assign released[i]   = release_q;
        assign long_press[i] = long_q;
    end

endmodule
